// File: rtl/four_12_12_st1_bias_ctrl_if.sv
// Bus bundle for the stage-1 bias controller: loader stream, datapath read port
// and the single-port bias memory interface.
interface four_12_12_st1_bias_ctrl_if #(
   parameter int unsigned AW = 2,
   parameter int unsigned DW = 32
);
   logic          bias_clr;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_gnt;
   logic          rd_data_valid;
   logic [DW-1:0] rd_data;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic          bias_loaded;
   logic [AW-1:0] wr_ptr;

   modport slave (
      input  bias_clr, ld_valid, ld_data, rd_req, rd_addr, mem_rd_data,
      output ld_ready, rd_gnt, rd_data_valid, rd_data,
             mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
             bias_loaded, wr_ptr
   );

   modport master (
      output bias_clr, ld_valid, ld_data, rd_req, rd_addr, mem_rd_data,
      input  ld_ready, rd_gnt, rd_data_valid, rd_data,
             mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
             bias_loaded, wr_ptr
   );
endinterface

// File: rtl/four_12_12_st1_bias_ctrl.sv
// Stage-1 bias memory sequencer: fills DEPTH entries in order, then shares the
// memory's single access per cycle between loader and reader round-robin.
module four_12_12_st1_bias_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2,
   parameter int unsigned DW    = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   four_12_12_st1_bias_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   typedef enum logic {
      GNT_READ  = 1'b0,
      GNT_WRITE = 1'b1
   } grant_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t        r_state;
   grant_t        r_last_grant;
   logic [AW-1:0] r_wr_ptr;
   logic          r_bias_loaded;
   logic          r_rd_data_valid;

   logic w_full;
   logic w_ld_ready;
   logic w_rd_gnt;
   logic w_wr;
   logic w_contend;
   logic w_ptr_last;

   // Once full, a lone requester always wins; under contention the side that
   // did not win last time is granted.
   always_comb begin
      w_full     = (r_state == ST_READY);
      w_ld_ready = 1'b0;
      w_rd_gnt   = 1'b0;
      if (w_full) begin
         w_ld_ready = bus.ld_valid && !bus.bias_clr &&
                      !(bus.rd_req && (r_last_grant == GNT_WRITE));
         w_rd_gnt   = bus.rd_req && !bus.bias_clr &&
                      !(bus.ld_valid && (r_last_grant == GNT_READ));
      end else begin
         w_ld_ready = !bus.bias_clr;
      end
      w_wr       = bus.ld_valid && w_ld_ready;
      w_contend  = w_full && bus.ld_valid && bus.rd_req && !bus.bias_clr;
      w_ptr_last = (r_wr_ptr == LAST_IDX);
   end

   always_comb begin
      bus.ld_ready      = w_ld_ready;
      bus.rd_gnt        = w_rd_gnt;
      bus.rd_data_valid = r_rd_data_valid;
      bus.rd_data       = bus.mem_rd_data;
      bus.mem_wr_en     = w_wr;
      bus.mem_wr_addr   = w_wr ? r_wr_ptr : '0;
      bus.mem_wr_data   = w_wr ? bus.ld_data : '0;
      bus.mem_rd_en     = w_rd_gnt;
      bus.mem_rd_addr   = w_rd_gnt ? bus.rd_addr : '0;
      bus.bias_loaded   = r_bias_loaded;
      bus.wr_ptr        = r_wr_ptr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= ST_EMPTY;
         r_last_grant    <= GNT_READ;
         r_wr_ptr        <= '0;
         r_bias_loaded   <= 1'b0;
         r_rd_data_valid <= 1'b0;
      end else begin
         // A read granted last cycle still completes even if cleared now.
         r_rd_data_valid <= w_rd_gnt;
         if (bus.bias_clr) begin
            r_state       <= ST_EMPTY;
            r_wr_ptr      <= '0;
            r_bias_loaded <= 1'b0;
         end else begin
            if (w_contend) begin
               r_last_grant <= w_wr ? GNT_WRITE : GNT_READ;
            end
            if (w_wr) begin
               r_wr_ptr <= w_ptr_last ? '0 : r_wr_ptr + AW'(1);
               if (w_ptr_last) begin
                  r_state       <= ST_READY;
                  r_bias_loaded <= 1'b1;
               end else if (r_state == ST_EMPTY) begin
                  r_state <= ST_FILL;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_four_12_12_st1_bias_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a write-count/arbitration model of the controller.
module tb_four_12_12_st1_bias_ctrl;

   localparam int DEPTH = 4;

   logic clk;
   logic reset;

   four_12_12_st1_bias_ctrl_if #(.AW(2), .DW(32)) bus ();

   four_12_12_st1_bias_ctrl #(.DEPTH(4), .AW(2), .DW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Single-port memory behind the controller, read data one cycle late.
   logic [31:0] tbmem [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) tbmem[i] = '0;
   always @(posedge clk) begin
      if (bus.mem_wr_en) tbmem[bus.mem_wr_addr] <= bus.mem_wr_data;
      if (bus.mem_rd_en)
         bus.mem_rd_data <= (bus.mem_wr_en && bus.mem_wr_addr == bus.mem_rd_addr)
                            ? bus.mem_wr_data : tbmem[bus.mem_rd_addr];
   end

   // Behavioural model: writes since clear, loader pointer, contention winner.
   int          m_count;
   int          m_ptr;
   bit          m_last_write;
   bit          m_pv;
   logic [31:0] m_pd;
   logic [31:0] refmem [DEPTH];
   bit          full, do_w, do_r, e_ldr;

   initial for (int i = 0; i < DEPTH; i++) refmem[i] = '0;

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_rd_data_valid", {31'd0, bus.rd_data_valid}, 32'd0);
         chk("rst_bias_loaded", {31'd0, bus.bias_loaded}, 32'd0);
         chk("rst_wr_ptr", {30'd0, bus.wr_ptr}, 32'd0);
         m_count = 0; m_ptr = 0; m_last_write = 0; m_pv = 0; m_pd = '0;
      end else begin
         full  = (m_count >= DEPTH);
         do_w  = 0;
         do_r  = 0;
         e_ldr = 0;
         if (!bus.bias_clr) begin
            if (!full) begin
               e_ldr = 1;
               do_w  = bus.ld_valid;
            end else if (bus.ld_valid && bus.rd_req) begin
               do_w = !m_last_write;
               do_r = m_last_write;
            end else begin
               do_w = bus.ld_valid;
               do_r = bus.rd_req;
            end
            if (full) e_ldr = do_w;
         end
         chk("ld_ready", {31'd0, bus.ld_ready}, {31'd0, e_ldr});
         chk("rd_gnt", {31'd0, bus.rd_gnt}, {31'd0, do_r});
         chk("mem_wr_en", {31'd0, bus.mem_wr_en}, {31'd0, do_w});
         chk("mem_wr_addr", {30'd0, bus.mem_wr_addr}, do_w ? m_ptr : 0);
         chk("mem_wr_data", bus.mem_wr_data, do_w ? bus.ld_data : 32'd0);
         chk("mem_rd_en", {31'd0, bus.mem_rd_en}, {31'd0, do_r});
         chk("mem_rd_addr", {30'd0, bus.mem_rd_addr}, do_r ? {30'd0, bus.rd_addr} : 32'd0);
         chk("rd_data_valid", {31'd0, bus.rd_data_valid}, {31'd0, m_pv});
         if (m_pv) chk("rd_data", bus.rd_data, m_pd);
         chk("bias_loaded", {31'd0, bus.bias_loaded}, {31'd0, full});
         chk("wr_ptr", {30'd0, bus.wr_ptr}, m_ptr);

         if (full && !bus.bias_clr && bus.ld_valid && bus.rd_req) m_last_write = do_w;
         if (do_w) begin
            refmem[m_ptr] = bus.ld_data;
            m_ptr = (m_ptr + 1) % DEPTH;
            if (m_count < DEPTH) m_count++;
         end
         m_pv = do_r;
         if (do_r) m_pd = refmem[bus.rd_addr];
         if (bus.bias_clr) begin
            m_count = 0;
            m_ptr   = 0;
         end
      end
   end

   task automatic idle_inputs();
      bus.bias_clr = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      bus.rd_req   = 1'b0;
      bus.rd_addr  = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic fill4(input logic [31:0] base);
      for (int i = 0; i < DEPTH; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = base + 32'(i);
         next_cycle();
      end
      bus.ld_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      chk("reset_loaded", {31'd0, bus.bias_loaded}, 32'd0);
      chk("reset_ptr", {30'd0, bus.wr_ptr}, 32'd0);
      next_cycle();
      reset = 1'b0;

      // Fill with a read request held high throughout.
      for (int i = 0; i < DEPTH; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = 32'h11 * (i + 1);
         bus.rd_req   = 1'b1;
         @(negedge clk);
         chk("fill_wr_addr", {30'd0, bus.mem_wr_addr}, i);
         chk("fill_rd_gnt", {31'd0, bus.rd_gnt}, 32'd0);
         chk("fill_loaded_early", {31'd0, bus.bias_loaded}, 32'd0);
         next_cycle();
         chk("fill_wr_ptr", {30'd0, bus.wr_ptr}, (i + 1) % DEPTH);
      end
      idle_inputs();
      chk("fill_loaded", {31'd0, bus.bias_loaded}, 32'd1);

      // Read latency: entry 2 holds 0x33.
      bus.rd_req  = 1'b1;
      bus.rd_addr = 2'd2;
      @(negedge clk);
      chk("lat_gnt", {31'd0, bus.rd_gnt}, 32'd1);
      chk("lat_addr", {30'd0, bus.mem_rd_addr}, 32'd2);
      next_cycle();
      bus.rd_req = 1'b0;
      @(negedge clk);
      chk("lat_valid", {31'd0, bus.rd_data_valid}, 32'd1);
      chk("lat_data", bus.rd_data, 32'h33);
      next_cycle();
      @(negedge clk);
      chk("lat_valid_drop", {31'd0, bus.rd_data_valid}, 32'd0);

      // Hot update of entry 0, read back the following cycle.
      next_cycle();
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'h55;
      @(negedge clk);
      chk("hot_wr_addr", {30'd0, bus.mem_wr_addr}, 32'd0);
      next_cycle();
      bus.ld_valid = 1'b0;
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 2'd0;
      chk("hot_ptr", {30'd0, bus.wr_ptr}, 32'd1);
      chk("hot_loaded", {31'd0, bus.bias_loaded}, 32'd1);
      next_cycle();
      bus.rd_req = 1'b0;
      @(negedge clk);
      chk("hot_data", bus.rd_data, 32'h55);

      // Contention: grants alternate starting with the writer.
      next_cycle();
      for (int k = 0; k < 6; k++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = 32'hA0 + 32'(k);
         bus.rd_req   = 1'b1;
         bus.rd_addr  = 2'd3;
         @(negedge clk);
         chk("cont_wr", {31'd0, bus.ld_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_rd", {31'd0, bus.rd_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
         chk("cont_excl", {31'd0, bus.mem_wr_en & bus.mem_rd_en}, 32'd0);
         next_cycle();
      end
      idle_inputs();

      // Clear right after a granted read; the read still completes.
      bus.rd_req  = 1'b1;
      bus.rd_addr = 2'd1;
      next_cycle();
      bus.rd_req   = 1'b0;
      bus.bias_clr = 1'b1;
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hDEAD;
      @(negedge clk);
      chk("clr_no_write", {31'd0, bus.mem_wr_en}, 32'd0);
      chk("clr_valid", {31'd0, bus.rd_data_valid}, 32'd1);
      chk("clr_data", bus.rd_data, 32'hA0);
      next_cycle();
      idle_inputs();
      chk("clr_ptr", {30'd0, bus.wr_ptr}, 32'd0);
      chk("clr_loaded", {31'd0, bus.bias_loaded}, 32'd0);

      // Clear in FILL with a competing write.
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'h1;
      next_cycle();
      bus.ld_data  = 32'h2;
      next_cycle();
      chk("fill2_ptr", {30'd0, bus.wr_ptr}, 32'd2);
      bus.bias_clr = 1'b1;
      @(negedge clk);
      chk("fillclr_no_write", {31'd0, bus.mem_wr_en}, 32'd0);
      next_cycle();
      idle_inputs();
      chk("fillclr_ptr", {30'd0, bus.wr_ptr}, 32'd0);

      // Asynchronous reset one cycle after a grant.
      fill4(32'h100);
      bus.rd_req  = 1'b1;
      bus.rd_addr = 2'd2;
      next_cycle();
      bus.rd_req = 1'b0;
      chk("ar_valid_pre", {31'd0, bus.rd_data_valid}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("ar_valid", {31'd0, bus.rd_data_valid}, 32'd0);
      chk("ar_loaded", {31'd0, bus.bias_loaded}, 32'd0);
      chk("ar_ptr", {30'd0, bus.wr_ptr}, 32'd0);
      next_cycle();
      reset = 1'b0;

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 799) == 0) begin
            idle_inputs();
            reset = 1'b1;
         end else begin
            reset        = 1'b0;
            bus.bias_clr = ($urandom_range(0, 39) == 0);
            bus.ld_valid = ($urandom_range(0, 9) < 6);
            bus.ld_data  = $urandom;
            bus.rd_req   = ($urandom_range(0, 9) < 6);
            bus.rd_addr  = 2'($urandom_range(0, 3));
         end
         next_cycle();
      end
      reset = 1'b0;
      idle_inputs();
      next_cycle();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
